lsu: RTL
========

# lsu

Load/store unit sitting directly downstream of the ALU in the RISC-V core. It takes the ALU result as the effective address for LB/LH/LW/LBU/LHU/SB/SH/SW. It runs a valid/ready transaction on the data-memory port, generates byte enables and aligned store data, and sign- or zero-extends load data. It stalls the core via `busy` until the access completes or faults.

## Interface
- `TIMEOUT`, default 16: maximum cycles in REQ without `memReady` before faulting; 0 disables the timeout.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: memory instruction present (level, from decode).
- `isStore` in 1: 1 = store, 0 = load.
- `funct3` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr` in 32: effective address (ALU `aluOut`).
- `storeData` in 32: rs2 value.
- `busy` out 1: stall the PC/core.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: misaligned, illegal funct3, or timeout; valid only with `done`.
- `loadData` out 32: extended load result, registered.
- `memReq` out 1: request valid.
- `memWe` out 1: write enable.
- `memAddr` out 32: word address, `{addr[31:2],2'b00}`.
- `memWdata` out 32: lane-replicated store data.
- `memBe` out 4: byte enables.
- `memReady` in 1: memory accepts/completes the request.
- `memRdata` in 32: read word, valid when `memReady`=1 on a read.

## Operation
- FSM states:
  - IDLE (reset state).
  - REQ.
  - DONE.
  - ERR.
- IDLE, `start`=1:
  - Latch `addr`, `storeData`, `funct3`, `isStore`.
  - Go to ERR if:
    - funct3 is 011/110/111, or
    - store with funct3 100/101, or
    - H/HU with `addr[0]`=1, or
    - W with `addr[1:0]`≠0.
  - Otherwise go to REQ.
- REQ: `memReq`=1 with stable address, data, enables and `memWe`.
  - `memReady`=1: for loads, capture the formatted `memRdata` into `loadData`; go to DONE.
  - Wait counter reaches `TIMEOUT`-1 without `memReady` (TIMEOUT>0): go to ERR and drop `memReq`.
- DONE: `done`=1, `fault`=0; go to IDLE. `start` is ignored in DONE.
- ERR: `done`=1, `fault`=1; go to IDLE; no memory transaction is issued. `loadData` is unchanged.
- Store formatting:
  - SB: `memBe`=`4'b0001<<addr[1:0]`, `memWdata`=`{4{storeData[7:0]}}`.
  - SH: `memBe`=`addr[1]`?`1100`:`0011`, `memWdata`=`{2{storeData[15:0]}}`.
  - SW: `memBe`=`1111`, `memWdata`=`storeData`.
- Loads drive the same `memBe` pattern; `memWdata` is don't-care.
- Load extraction:
  - Lane = `memRdata >> (8*addr[1:0])`.
  - B/H are sign-extended from bit 7/15.
  - BU/HU are zero-extended.
  - W passes through.
- `busy` = (IDLE && `start`) || REQ. It is combinational on `start`, so the core stalls in the start cycle. It is 0 in DONE/ERR, so the core advances at the end of the `done` cycle.
- `start` while not in IDLE is ignored.

## Timing
- Reset values:
  - State IDLE; wait counter 0.
  - `busy`=0 unless `start` (combinational).
  - `done`=0, `fault`=0, `memReq`=0, `memWe`=0.
  - `memAddr`=0, `memWdata`=0, `memBe`=0, `loadData`=0.
- Latency with zero-wait memory (`start` in cycle 0, `memReady` first sampled in cycle 1):
  - `memReq` in cycle 1.
  - `done` in cycle 2.
  - Each extra memory wait cycle adds 1.
- Fault latency: `done`+`fault` in cycle 1; `memReq` is never asserted.
- Timeout: with `memReady` held 0, `memReq` is high for exactly `TIMEOUT` cycles, then ERR.
- `memReq` falls on the cycle after `memReady` is seen; the memory must not expect a second beat.
- `rst` during REQ: next cycle IDLE with `memReq`=0. The memory must tolerate an abandoned request.
- `loadData` holds its value until the next completed load.

## Test plan
- LW `addr`=0x104, `memRdata`=0xDEADBEEF, `memReady`=1 in cycle 1 -> `memAddr`=0x104, `memBe`=1111, `done` cycle 2, `loadData`=0xDEADBEEF, `fault`=0.
- LB/LBU `addr`=0x103, `memRdata`=0x80FF0000 -> LB gives `loadData`=0xFFFFFF80; LBU gives 0x00000080.
- SH `addr`=0x22, `storeData`=0x1234ABCD, `memReady` delayed 3 cycles -> `memWe`=1, `memBe`=1100, `memWdata`=0xABCDABCD, `memReq` held 4 cycles, `done` cycle 5.
- LW `addr`=0x102 and LH `addr`=0x101 -> `done`+`fault` in cycle 1, `memReq` never high. Same for funct3=011 and for SB with funct3=100.
- `TIMEOUT`=4, `memReady` stuck 0 -> `memReq` high cycles 1–4, `fault`+`done` cycle 5, `busy` high cycles 0–4.
- Assert `rst` in cycle 2 of a waited load -> cycle 3 IDLE, `memReq`=0, `done`=0, `loadData`=0. A following new LW completes normally.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: issues a single valid/ready data-memory access for
// RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW and formats store lanes and load results.
module lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        isStore,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] loadData,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memBe,
  input  logic        memReady,
  input  logic [31:0] memRdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] cnt_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        done_q;
  logic        fault_q;
  logic        memReq_q;
  logic        memWe_q;
  logic [31:0] memAddr_q;
  logic [31:0] memWdata_q;
  logic [3:0]  memBe_q;
  logic [31:0] loadData_q;

  function automatic logic is_illegal(input logic [2:0] f3, input logic st,
                                      input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = a[0];
      3'b010:  bad = (a != 2'b00);
      3'b100:  bad = st;
      3'b101:  bad = st | a[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] rd);
    logic [31:0] lane;
    logic [31:0] r;
    lane = rd >> {a, 3'b000};
    case (f3)
      3'b000:  r = {{24{lane[7]}}, lane[7:0]};
      3'b001:  r = {{16{lane[15]}}, lane[15:0]};
      3'b100:  r = {24'd0, lane[7:0]};
      3'b101:  r = {16'd0, lane[15:0]};
      default: r = lane;
    endcase
    return r;
  endfunction

  // Stall is combinational on start so the core holds in the issue cycle.
  assign busy     = ((state_q == IDLE) && start) || (state_q == REQ);
  assign done     = done_q;
  assign fault    = fault_q;
  assign memReq   = memReq_q;
  assign memWe    = memWe_q;
  assign memAddr  = memAddr_q;
  assign memWdata = memWdata_q;
  assign memBe    = memBe_q;
  assign loadData = loadData_q;

  // Control FSM with registered memory-port and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 32'd0;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= 32'd0;
      memWdata_q <= 32'd0;
      memBe_q    <= 4'b0000;
      loadData_q <= 32'd0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            f3_q  <= funct3;
            off_q <= addr[1:0];
            if (is_illegal(funct3, isStore, addr[1:0])) begin
              state_q <= ERR;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              state_q    <= REQ;
              cnt_q      <= 32'd0;
              memReq_q   <= 1'b1;
              memWe_q    <= isStore;
              memAddr_q  <= {addr[31:2], 2'b00};
              memBe_q    <= byte_en(funct3, addr[1:0]);
              memWdata_q <= store_lanes(funct3, storeData);
            end
          end
        end
        REQ: begin
          if (memReady) begin
            if (!memWe_q) begin
              loadData_q <= load_extract(f3_q, off_q, memRdata);
            end
            state_q  <= DONE;
            done_q   <= 1'b1;
            memReq_q <= 1'b0;
            memWe_q  <= 1'b0;
          end else if ((TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1))) begin
            state_q  <= ERR;
            done_q   <= 1'b1;
            fault_q  <= 1'b1;
            memReq_q <= 1'b0;
            memWe_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
